aludec_pipe: RTL and testbench
==============================

# aludec_pipe

Registered, flow-controlled successor to the combinational ALU decoder. Accepts one 32-bit MIPS instruction per cycle over a valid/ready handshake, decodes op/funct into the 8-bit ALU control code, and presents it one cycle later with a passthrough copy of the instruction. A two-entry skid buffer decouples decode from execute back-pressure. Flush and reserved-instruction detection are included. Sits between the ID-stage instruction register and the EX-stage ALU/mul-div issue logic.

## Interface
- `INSTR_W`, 32: instruction width. Op field is `[INSTR_W-1 -: 6]`; funct field is `[5:0]`.
- `CTRL_W`, 8: ALU control code width. Must match the `EXE_*_OP` encodings.
- `CNT_W`, 16: width of the decoded-instruction counter.
- `clk`  in  1: single clock. All state is updated on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous; discards all buffered entries.
- `in_valid`  in  1: upstream has an instruction.
- `in_ready`  out  1: decoder can accept an instruction.
- `in_instr`  in  INSTR_W: instruction word.
- `out_valid`  out  1: decoded entry available.
- `out_ready`  in  1: downstream accepts the entry.
- `out_instr`  out  INSTR_W: instruction passthrough.
- `out_alucontrol`  out  CTRL_W: decoded ALU control code.
- `out_ri`  out  1: reserved/unsupported instruction.
- `dec_count`  out  CNT_W: count of accepted instructions.

## Operation
- Decode table (op = 0, funct-selected): AND, OR, XOR, NOR, SLL, SRL, SRA, SLLV, SRLV, SRAV, MFHI, MTHI, MFLO, MTLO, ADD, ADDU, SUB, SUBU, SLT, SLTU, MULT, MULTU, DIV, DIVU. Each maps to its `EXE_*_OP` code.
- Decode table (op-selected): ANDI, XORI, LUI, ORI, ADDI, ADDIU, SLTI, SLTIU, LB, LBU, LH, LHU, LW, SB, SH, SW, BEQ. Each maps to its `EXE_*_OP` code.
- Unmatched op, or op = 0 with an unmatched funct: `out_alucontrol` = 0 and `out_ri` = 1 (see Configuration).
- Decode is fully specified for every input. There is no held or latched value.
- Storage consists of a main register (M) and a skid register (S), each holding valid, instr, ctrl and ri.
- States:
  - EMPTY (M and S invalid)
  - ONE (M valid)
  - FULL (M and S valid)
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- EMPTY: on transfer in → ONE.
- ONE:
  - In only → FULL; the new entry goes to S.
  - Out only → EMPTY.
  - In and out together → ONE; M takes the new entry.
- FULL:
  - Out → ONE; M takes S.
  - In is blocked because `in_ready` = 0.
- Ordering is strictly FIFO. No entry is lost or duplicated.
- `dec_count` increments by 1 per transfer in and wraps from 2^CNT_W−1 to 0.
- `flush` (synchronous, highest priority): M and S are invalidated. A transfer in during the same cycle is discarded and not counted. `dec_count` is retained.

## Timing
- Latency: an instruction accepted at edge N is visible on `out_*` after edge N (one cycle).
- Throughput: 1 instruction/cycle while `out_ready` = 1.
- `in_ready` = !S.valid, driven from a register with no combinational path from `out_ready`.
- `out_valid` = M.valid, also registered.
- `out_*` data is stable while `out_valid & !out_ready`.
- Reset values (asynchronous on `resetn` = 0):
  - `out_valid` = 0, `in_ready` = 1
  - `out_instr` = 0, `out_alucontrol` = 0, `out_ri` = 0
  - `dec_count` = 0
- Reset asserted mid-stream drops all entries immediately. The first transfer in is possible on the first edge after deassertion.
- `in_instr` is sampled only on a transfer in. It may be X otherwise.

## Configuration
- `ALUDEC_RI_EXCEPTION_EN` defined:
  - `out_ri` is driven by decode as described in Operation.
  - `dec_count` counts only entries with ri = 0.
- `ALUDEC_RI_EXCEPTION_EN` undefined:
  - `out_ri` is tied to 0 and the ri bit is not stored.
  - Unknown encodings still produce `out_alucontrol` = 0.
  - `dec_count` counts all accepted entries.

## Structure
- `EXE_*` opcode/funct constants and `EXE_*_OP` control codes live in the shared defines header. Nothing is redefined locally.
- Combinational decode is a sub-module, `aludec_comb` (in: op, funct; out: alucontrol, ri). It is instantiated once, on the input side.
- The skid/handshake logic and the counter live in `aludec_pipe`.

## Test plan
- `and $2,$4,$5` (0x00851024), with `out_ready` = 1:
  - One cycle later: `out_valid` = 1, `out_alucontrol` = EXE_AND_OP, `out_ri` = 0, `dec_count` = 1.
- Back-to-back 0x20020005 (ADDI), 0x8C430000 (LW), 0x10220003 (BEQ):
  - Outputs EXE_ADDI_OP, EXE_LW_OP, EXE_BEQ_OP on consecutive cycles, with no bubbles.
- Op 0x3F (0xFC000000), and op 0 with funct 0x3F:
  - `out_alucontrol` = 0, `out_ri` = 1 (macro on).
  - `out_ri` = 0 (macro off).
- `out_ready` held 0 for 4 cycles while 3 instructions are offered:
  - `in_ready` falls after the 2nd accept; the 3rd is held upstream.
  - After release, all 3 emerge in order.
  - `dec_count` = 3.
- FULL state plus `flush` with a simultaneous `in_valid`:
  - Next cycle `out_valid` = 0 and `in_ready` = 1; the flushed-cycle input never appears.
  - `dec_count` is unchanged.
- `resetn` pulsed low for half a cycle while FULL:
  - All outputs go to their reset values immediately.
  - The next accepted instruction emerges first.

Source files
------------

// File: rtl/aludec_pipe_pkg.sv
// Shared MIPS opcode/funct encodings, EXE_*_OP ALU control codes and skid-buffer state type.
// Consumers: aludec_comb, aludec_pipe (optional ALUDEC_RI_EXCEPTION_EN feature lives in aludec_pipe).
package aludec_pipe_pkg;

  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;

  // funct field encodings (op = SPECIAL)
  localparam logic [5:0] EXE_AND   = 6'b100100;
  localparam logic [5:0] EXE_OR    = 6'b100101;
  localparam logic [5:0] EXE_XOR   = 6'b100110;
  localparam logic [5:0] EXE_NOR   = 6'b100111;
  localparam logic [5:0] EXE_SLL   = 6'b000000;
  localparam logic [5:0] EXE_SRL   = 6'b000010;
  localparam logic [5:0] EXE_SRA   = 6'b000011;
  localparam logic [5:0] EXE_SLLV  = 6'b000100;
  localparam logic [5:0] EXE_SRLV  = 6'b000110;
  localparam logic [5:0] EXE_SRAV  = 6'b000111;
  localparam logic [5:0] EXE_MFHI  = 6'b010000;
  localparam logic [5:0] EXE_MTHI  = 6'b010001;
  localparam logic [5:0] EXE_MFLO  = 6'b010010;
  localparam logic [5:0] EXE_MTLO  = 6'b010011;
  localparam logic [5:0] EXE_ADD   = 6'b100000;
  localparam logic [5:0] EXE_ADDU  = 6'b100001;
  localparam logic [5:0] EXE_SUB   = 6'b100010;
  localparam logic [5:0] EXE_SUBU  = 6'b100011;
  localparam logic [5:0] EXE_SLT   = 6'b101010;
  localparam logic [5:0] EXE_SLTU  = 6'b101011;
  localparam logic [5:0] EXE_MULT  = 6'b011000;
  localparam logic [5:0] EXE_MULTU = 6'b011001;
  localparam logic [5:0] EXE_DIV   = 6'b011010;
  localparam logic [5:0] EXE_DIVU  = 6'b011011;

  // op field encodings
  localparam logic [5:0] EXE_ANDI  = 6'b001100;
  localparam logic [5:0] EXE_ORI   = 6'b001101;
  localparam logic [5:0] EXE_XORI  = 6'b001110;
  localparam logic [5:0] EXE_LUI   = 6'b001111;
  localparam logic [5:0] EXE_ADDI  = 6'b001000;
  localparam logic [5:0] EXE_ADDIU = 6'b001001;
  localparam logic [5:0] EXE_SLTI  = 6'b001010;
  localparam logic [5:0] EXE_SLTIU = 6'b001011;
  localparam logic [5:0] EXE_LB    = 6'b100000;
  localparam logic [5:0] EXE_LBU   = 6'b100100;
  localparam logic [5:0] EXE_LH    = 6'b100001;
  localparam logic [5:0] EXE_LHU   = 6'b100101;
  localparam logic [5:0] EXE_LW    = 6'b100011;
  localparam logic [5:0] EXE_SB    = 6'b101000;
  localparam logic [5:0] EXE_SH    = 6'b101001;
  localparam logic [5:0] EXE_SW    = 6'b101011;
  localparam logic [5:0] EXE_BEQ   = 6'b000100;

  // ALU control codes
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b01011001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b01011010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b01011011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_LB_OP    = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP   = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP    = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP   = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP    = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP    = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP    = 8'b11101011;
  localparam logic [7:0] EXE_BEQ_OP   = 8'b01010001;

  // Bit 0 = M valid, bit 1 = S valid, so handshake outputs come straight off flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } skid_state_t;

endpackage

// File: rtl/aludec_comb.sv
// Combinational MIPS op/funct to ALU control decode; unmatched encodings give code 0 with ri set.
module aludec_comb
  import aludec_pipe_pkg::*;
#(
  parameter int CTRL_W = 8
) (
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              ri
);

  logic [7:0] code;

  always_comb begin
    code = 8'h00;
    ri   = 1'b0;
    case (op)
      EXE_SPECIAL_INST: begin
        case (funct)
          EXE_AND:   code = EXE_AND_OP;
          EXE_OR:    code = EXE_OR_OP;
          EXE_XOR:   code = EXE_XOR_OP;
          EXE_NOR:   code = EXE_NOR_OP;
          EXE_SLL:   code = EXE_SLL_OP;
          EXE_SRL:   code = EXE_SRL_OP;
          EXE_SRA:   code = EXE_SRA_OP;
          EXE_SLLV:  code = EXE_SLLV_OP;
          EXE_SRLV:  code = EXE_SRLV_OP;
          EXE_SRAV:  code = EXE_SRAV_OP;
          EXE_MFHI:  code = EXE_MFHI_OP;
          EXE_MTHI:  code = EXE_MTHI_OP;
          EXE_MFLO:  code = EXE_MFLO_OP;
          EXE_MTLO:  code = EXE_MTLO_OP;
          EXE_ADD:   code = EXE_ADD_OP;
          EXE_ADDU:  code = EXE_ADDU_OP;
          EXE_SUB:   code = EXE_SUB_OP;
          EXE_SUBU:  code = EXE_SUBU_OP;
          EXE_SLT:   code = EXE_SLT_OP;
          EXE_SLTU:  code = EXE_SLTU_OP;
          EXE_MULT:  code = EXE_MULT_OP;
          EXE_MULTU: code = EXE_MULTU_OP;
          EXE_DIV:   code = EXE_DIV_OP;
          EXE_DIVU:  code = EXE_DIVU_OP;
          default:   ri   = 1'b1;
        endcase
      end
      EXE_ANDI:  code = EXE_ANDI_OP;
      EXE_XORI:  code = EXE_XORI_OP;
      EXE_LUI:   code = EXE_LUI_OP;
      EXE_ORI:   code = EXE_ORI_OP;
      EXE_ADDI:  code = EXE_ADDI_OP;
      EXE_ADDIU: code = EXE_ADDIU_OP;
      EXE_SLTI:  code = EXE_SLTI_OP;
      EXE_SLTIU: code = EXE_SLTIU_OP;
      EXE_LB:    code = EXE_LB_OP;
      EXE_LBU:   code = EXE_LBU_OP;
      EXE_LH:    code = EXE_LH_OP;
      EXE_LHU:   code = EXE_LHU_OP;
      EXE_LW:    code = EXE_LW_OP;
      EXE_SB:    code = EXE_SB_OP;
      EXE_SH:    code = EXE_SH_OP;
      EXE_SW:    code = EXE_SW_OP;
      EXE_BEQ:   code = EXE_BEQ_OP;
      default:   ri   = 1'b1;
    endcase
  end

  assign alucontrol = CTRL_W'(code);

endmodule

// File: rtl/aludec_pipe.sv
// Registered ALU decoder with a two-entry skid buffer (M main, S skid) and accepted-instruction counter.
// ALUDEC_RI_EXCEPTION_EN: store/report ri and count only ri=0 entries; otherwise out_ri is 0.
module aludec_pipe
  import aludec_pipe_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CTRL_W-1:0]  out_alucontrol,
  output logic               out_ri,
  output logic [CNT_W-1:0]   dec_count
);

  skid_state_t state, state_nxt;
  logic [CTRL_W-1:0]  dec_ctrl, m_ctrl, s_ctrl;
  logic               dec_ri;
  logic [INSTR_W-1:0] m_instr, s_instr;
  logic               xfer_in, xfer_out, load_m_in, load_m_s, load_s, cnt_en;

  aludec_comb #(.CTRL_W(CTRL_W)) u_dec (
    .op        (in_instr[INSTR_W-1 -: 6]),
    .funct     (in_instr[5:0]),
    .alucontrol(dec_ctrl),
    .ri        (dec_ri)
  );

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (xfer_in) begin
          state_nxt = ONE;
          load_m_in = 1'b1;
        end
        ONE: case ({xfer_in, xfer_out})
          2'b10: begin
            state_nxt = FULL;
            load_s    = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: load_m_in = 1'b1;
          default: ;
        endcase
        FULL: if (xfer_out) begin
          state_nxt = ONE;
          load_m_s  = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_instr <= '0;
      m_ctrl  <= '0;
      s_instr <= '0;
      s_ctrl  <= '0;
    end else begin
      if (load_m_in) begin
        m_instr <= in_instr;
        m_ctrl  <= dec_ctrl;
      end else if (load_m_s) begin
        m_instr <= s_instr;
        m_ctrl  <= s_ctrl;
      end
      if (load_s) begin
        s_instr <= in_instr;
        s_ctrl  <= dec_ctrl;
      end
    end
  end

`ifdef ALUDEC_RI_EXCEPTION_EN
  logic m_ri, s_ri;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ri <= 1'b0;
      s_ri <= 1'b0;
    end else begin
      if (load_m_in)     m_ri <= dec_ri;
      else if (load_m_s) m_ri <= s_ri;
      if (load_s)        s_ri <= dec_ri;
    end
  end

  assign out_ri = m_ri;
  assign cnt_en = xfer_in & ~flush & ~dec_ri;
`else
  logic unused_ri;
  assign unused_ri = dec_ri;
  assign out_ri    = 1'b0;
  assign cnt_en    = xfer_in & ~flush;
`endif

  assign out_instr      = m_instr;
  assign out_alucontrol = m_ctrl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     dec_count <= '0;
    else if (cnt_en) dec_count <= dec_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_aludec_pipe.sv
// Self-checking bench for aludec_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_aludec_pipe;
  import aludec_pipe_pkg::*;

`ifdef ALUDEC_RI_EXCEPTION_EN
  localparam bit RI_EN = 1'b1;
`else
  localparam bit RI_EN = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid, out_ri;
  logic [31:0] out_instr;
  logic [7:0]  out_alucontrol;
  logic [15:0] dec_count;

  aludec_pipe #(.INSTR_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_alucontrol(out_alucontrol), .out_ri(out_ri), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  ctrl;
    logic        ri;
  } exp_t;

  int          errors = 0, checks = 0;
  exp_t        q[$];
  logic [15:0] cnt_m = '0;
  logic [7:0]  rtab[int];
  logic [7:0]  itab[int];
  int          fkeys[$], okeys[$];

  // MIPS ISA tables: funct (op=0) and op keyed, values are the expected control codes.
  task automatic init_tables();
    rtab[32'h24] = EXE_AND_OP;  rtab[32'h25] = EXE_OR_OP;    rtab[32'h26] = EXE_XOR_OP;
    rtab[32'h27] = EXE_NOR_OP;  rtab[32'h00] = EXE_SLL_OP;   rtab[32'h02] = EXE_SRL_OP;
    rtab[32'h03] = EXE_SRA_OP;  rtab[32'h04] = EXE_SLLV_OP;  rtab[32'h06] = EXE_SRLV_OP;
    rtab[32'h07] = EXE_SRAV_OP; rtab[32'h10] = EXE_MFHI_OP;  rtab[32'h11] = EXE_MTHI_OP;
    rtab[32'h12] = EXE_MFLO_OP; rtab[32'h13] = EXE_MTLO_OP;  rtab[32'h20] = EXE_ADD_OP;
    rtab[32'h21] = EXE_ADDU_OP; rtab[32'h22] = EXE_SUB_OP;   rtab[32'h23] = EXE_SUBU_OP;
    rtab[32'h2A] = EXE_SLT_OP;  rtab[32'h2B] = EXE_SLTU_OP;  rtab[32'h18] = EXE_MULT_OP;
    rtab[32'h19] = EXE_MULTU_OP; rtab[32'h1A] = EXE_DIV_OP;  rtab[32'h1B] = EXE_DIVU_OP;
    itab[32'h0C] = EXE_ANDI_OP; itab[32'h0E] = EXE_XORI_OP;  itab[32'h0F] = EXE_LUI_OP;
    itab[32'h0D] = EXE_ORI_OP;  itab[32'h08] = EXE_ADDI_OP;  itab[32'h09] = EXE_ADDIU_OP;
    itab[32'h0A] = EXE_SLTI_OP; itab[32'h0B] = EXE_SLTIU_OP; itab[32'h20] = EXE_LB_OP;
    itab[32'h24] = EXE_LBU_OP;  itab[32'h21] = EXE_LH_OP;    itab[32'h25] = EXE_LHU_OP;
    itab[32'h23] = EXE_LW_OP;   itab[32'h28] = EXE_SB_OP;    itab[32'h29] = EXE_SH_OP;
    itab[32'h2B] = EXE_SW_OP;   itab[32'h04] = EXE_BEQ_OP;
    foreach (rtab[k]) fkeys.push_back(k);
    foreach (itab[k]) okeys.push_back(k);
  endtask

  function automatic exp_t ref_dec(logic [31:0] w);
    exp_t e;
    int op = int'(w[31:26]);
    int fn = int'(w[5:0]);
    e.instr = w; e.ctrl = 8'h00; e.ri = 1'b1;
    if (op == 0) begin
      if (rtab.exists(fn)) begin e.ctrl = rtab[fn]; e.ri = 1'b0; end
    end else if (itab.exists(op)) begin
      e.ctrl = itab[op]; e.ri = 1'b0;
    end
    if (!RI_EN) e.ri = 1'b0;
    return e;
  endfunction

  // One clock: model is a depth-2 FIFO; accept decided from pre-edge occupancy.
  task automatic step();
    exp_t e;
    bit acc, pop;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    if (acc) e = ref_dec(in_instr);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (!e.ri) cnt_m = cnt_m + 16'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_instr, out_alucontrol, out_ri} !== 41'd0) begin errors++; $display("FAIL reset_data: got %h/%h/%b want 0", out_instr, out_alucontrol, out_ri); end
    checks++; if (dec_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dec_count); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and();
    in_valid = 1'b1; in_instr = 32'h00851024; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid: got %b want 1", out_valid); end
    checks++; if (out_alucontrol !== EXE_AND_OP || out_ri !== 1'b0) begin errors++; $display("FAIL and_ctrl: got %h ri %b want %h ri 0", out_alucontrol, out_ri, EXE_AND_OP); end
    checks++; if (dec_count !== 16'd1) begin errors++; $display("FAIL and_count: got %0d want 1", dec_count); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [7:0]  c[3];
    w = '{32'h20020005, 32'h8C430000, 32'h10220003};
    c = '{EXE_ADDI_OP, EXE_LW_OP, EXE_BEQ_OP};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = w[i];
      step();
      checks++; if (out_valid !== 1'b1 || out_alucontrol !== c[i] || out_instr !== w[i]) begin
        errors++; $display("FAIL b2b_%0d: got v%b %h %h want v1 %h %h", i, out_valid, out_instr, out_alucontrol, w[i], c[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reserved();
    logic [31:0] w[2];
    logic [15:0] c0;
    w = '{32'hFC000000, 32'h0000003F};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      c0 = cnt_m;
      in_valid = 1'b1; in_instr = w[i];
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_alucontrol !== 8'h00 || out_ri !== RI_EN) begin
        errors++; $display("FAIL ri_%0d: got v%b ctrl %h ri %b want v1 ctrl 00 ri %b", i, out_valid, out_alucontrol, out_ri, RI_EN);
      end
      checks++; if (dec_count !== (RI_EN ? c0 : c0 + 16'd1)) begin
        errors++; $display("FAIL ri_count_%0d: got %0d want %0d", i, dec_count, RI_EN ? c0 : c0 + 16'd1);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    logic [15:0] c0;
    int idx;
    w = '{32'h01095020, 32'h3C010010, 32'hAC220004};
    c0 = cnt_m; idx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = 1'b1; in_instr = w[idx];
      if (q.size() < 2) idx++;
      step();
      if (cyc == 1) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_fall: got %b want 0", in_ready); end
      end
    end
    checks++; if (out_instr !== w[0] || idx != 2) begin errors++; $display("FAIL bp_hold: got %h want %h", out_instr, w[0]); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (idx < 3) begin in_valid = 1'b1; in_instr = w[idx]; end else in_valid = 1'b0;
      if (idx < 3 && q.size() < 2) idx++;
      checks++; if (out_valid !== 1'b1 || out_instr !== w[k]) begin
        errors++; $display("FAIL bp_order_%0d: got v%b %h want v1 %h", k, out_valid, out_instr, w[k]);
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    checks++; if (dec_count !== c0 + 16'd3) begin errors++; $display("FAIL bp_count: got %0d want %0d", dec_count, c0 + 16'd3); end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00A63025; step();
    in_instr = 32'h30E7FFFF; step();
    c0 = cnt_m;
    flush = 1'b1; in_instr = 32'h01284822;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got v%b r%b want v0 r1", out_valid, in_ready); end
    checks++; if (dec_count !== c0) begin errors++; $display("FAIL flush_count: got %0d want %0d", dec_count, c0); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00431024; step();
    in_instr = 32'h00431025; step();
    in_valid = 1'b0;
    resetn = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mrst_hs: got v%b r%b want v0 r1", out_valid, in_ready); end
    checks++; if ({out_instr, out_alucontrol, out_ri} !== 41'd0 || dec_count !== 16'd0) begin
      errors++; $display("FAIL mrst_data: got %h/%h/%b cnt %0d want zeros", out_instr, out_alucontrol, out_ri, dec_count);
    end
    #3 resetn = 1'b1;
    q.delete(); cnt_m = '0;
    in_valid = 1'b1; in_instr = 32'h24420001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h24420001 || out_alucontrol !== EXE_ADDIU_OP || dec_count !== 16'd1) begin
      errors++; $display("FAIL mrst_first: got v%b %h %h cnt %0d want v1 24420001 %h cnt 1", out_valid, out_instr, out_alucontrol, dec_count, EXE_ADDIU_OP);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin w[31:26] = 6'd0; w[5:0] = 6'(fkeys[$urandom_range(0, fkeys.size() - 1)]); end
        4, 5, 6, 7: w[31:26] = 6'(okeys[$urandom_range(0, okeys.size() - 1)]);
        default: ;
      endcase
      in_instr  = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready, q.size() < 2); end
      checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, dec_count, cnt_m); end
      if (q.size() > 0) begin
        checks++; if (out_instr !== q[0].instr || out_alucontrol !== q[0].ctrl || out_ri !== q[0].ri) begin
          errors++; $display("FAIL rnd_data@%0d: got %h %h %b want %h %h %b", n, out_instr, out_alucontrol, out_ri, q[0].instr, q[0].ctrl, q[0].ri);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    init_tables();
    test_reset();
    test_and();
    test_back_to_back();
    test_reserved();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
